// File: rtl/alu_mdu.sv
// alu_mdu: registered single-cycle ALU plus an iterative multiply/divide
// unit with HI/LO registers behind a valid/ready issue handshake.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int PC_W  = 30,
    parameter int SH_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             kill,
    input  logic [4:0]       aluop,
    input  logic [SH_W-1:0]  shamt,
    input  logic [PC_W-1:0]  cur_pc,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_SLT   = 5'b00010;
    localparam logic [4:0] OP_AND   = 5'b00011;
    localparam logic [4:0] OP_NOR   = 5'b00100;
    localparam logic [4:0] OP_OR    = 5'b00101;
    localparam logic [4:0] OP_XOR   = 5'b00110;
    localparam logic [4:0] OP_SLL   = 5'b00111;
    localparam logic [4:0] OP_SRL   = 5'b01000;
    localparam logic [4:0] OP_SLTU  = 5'b01001;
    localparam logic [4:0] OP_JALR  = 5'b01010;
    localparam logic [4:0] OP_SLLV  = 5'b01100;
    localparam logic [4:0] OP_SRA   = 5'b01101;
    localparam logic [4:0] OP_SRAV  = 5'b01110;
    localparam logic [4:0] OP_SRLV  = 5'b01111;
    localparam logic [4:0] OP_LUI   = 5'b10000;
    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_DIV   = 5'b10011;
    localparam logic [4:0] OP_DIVU  = 5'b10100;
    localparam logic [4:0] OP_MFHI  = 5'b10101;
    localparam logic [4:0] OP_MFLO  = 5'b10110;
    localparam logic [4:0] OP_MTHI  = 5'b10111;
    localparam logic [4:0] OP_MTLO  = 5'b11000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam int W2 = 2 * WIDTH;
    localparam logic [SH_W-1:0] LAST = SH_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic             div_q, div_d;
    logic             negp_q, negp_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic             pend_q, pend_d;
    logic [4:0]       op_q, op_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             in_multi;
    logic             in_signed;
    logic             in_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign in_ready  = (state_q == S_IDLE);
    assign accept    = in_valid && in_ready && !kill;
    assign in_multi  = (aluop == OP_MULT) || (aluop == OP_MULTU) ||
                       (aluop == OP_DIV)  || (aluop == OP_DIVU);
    assign in_signed = (aluop == OP_MULT) || (aluop == OP_DIV);
    assign in_div    = (aluop == OP_DIV)  || (aluop == OP_DIVU);
    assign a_neg     = in_signed && DataA[WIDTH-1];
    assign b_neg     = in_signed && DataB[WIDTH-1];
    assign a_mag     = a_neg ? -DataA : DataA;
    assign b_mag     = b_neg ? -DataB : DataB;

    // Single-cycle ops execute one cycle after acceptance from captured operands
    logic [WIDTH-1:0] alu_res;
    logic             alu_wr;
    logic [PC_W-1:0]  pc_inc;

    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        alu_res = result_q;
        alu_wr  = 1'b1;
        unique case (op_q)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_SLT:  alu_res = WIDTH'($signed(a_q) < $signed(b_q));
            OP_SLTU: alu_res = WIDTH'(a_q < b_q);
            OP_AND:  alu_res = a_q & b_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SLL:  alu_res = b_q << sh_q;
            OP_SRL:  alu_res = b_q >> sh_q;
            OP_SRA:  alu_res = $signed(b_q) >>> sh_q;
            OP_SLLV: alu_res = b_q << a_q[SH_W-1:0];
            OP_SRLV: alu_res = b_q >> a_q[SH_W-1:0];
            OP_SRAV: alu_res = $signed(b_q) >>> a_q[SH_W-1:0];
            OP_JALR: alu_res = WIDTH'(pc_inc);
            OP_LUI:  alu_res = b_q << (WIDTH / 2);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_wr  = 1'b0;
        endcase
    end

    logic [WIDTH-1:0] mul_add;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic [WIDTH:0]   div_tmp;
    logic [WIDTH:0]   div_diff;
    logic [W2-1:0]    div_next;

    assign mul_add  = acc_q[0] ? opd_q : {WIDTH{1'b0}};
    assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, mul_add};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_tmp  = acc_q[W2-1:WIDTH-1];
    assign div_diff = div_tmp - {1'b0, opd_q};
    assign div_next = div_diff[WIDTH]
                    ? {div_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    assign prod = negp_q ? -acc_q : acc_q;
    assign quo  = negp_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = negr_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

    // MIN / -1 needs no special case: |MIN| / 1 already yields MIN, rem 0
    always_comb begin
        fix_hi = prod[W2-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (div_q) begin
            fix_hi = dz_q ? a_q : rem;
            fix_lo = dz_q ? {WIDTH{1'b1}} : quo;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opd_d       = opd_q;
        div_d       = div_q;
        negp_d      = negp_q;
        negr_d      = negr_q;
        dz_d        = dz_q;
        op_d        = op_q;
        sh_d        = sh_q;
        pc_d        = pc_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        zero_d      = zero_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        pend_d      = 1'b0;
        out_valid_d = 1'b0;

        if (accept) begin
            op_d   = aluop;
            sh_d   = shamt;
            pc_d   = cur_pc;
            a_d    = DataA;
            b_d    = DataB;
            pend_d = !in_multi;
        end

        if (pend_q) begin
            out_valid_d = 1'b1;
            if (alu_wr) begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
            end
            if (op_q == OP_MTHI) hi_d = a_q;
            if (op_q == OP_MTLO) lo_d = a_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept && in_multi) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    opd_d   = in_div ? b_mag : a_mag;
                    acc_d   = {{WIDTH{1'b0}}, in_div ? a_mag : b_mag};
                    div_d   = in_div;
                    negp_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    dz_d    = (DataB == '0);
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = div_q ? div_next : mul_next;
                    cnt_d = cnt_q + SH_W'(1);
                    if (cnt_q == LAST) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!kill) begin
                    hi_d        = fix_hi;
                    lo_d        = fix_lo;
                    result_d    = fix_lo;
                    zero_d      = (fix_lo == '0);
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opd_q       <= '0;
            div_q       <= 1'b0;
            negp_q      <= 1'b0;
            negr_q      <= 1'b0;
            dz_q        <= 1'b0;
            pend_q      <= 1'b0;
            op_q        <= '0;
            sh_q        <= '0;
            pc_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opd_q       <= opd_d;
            div_q       <= div_d;
            negp_q      <= negp_d;
            negr_q      <= negr_d;
            dz_q        <= dz_d;
            pend_q      <= pend_d;
            op_q        <= op_d;
            sh_q        <= sh_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
